capture_ctrl: RTL and testbench
===============================

// Module: capture_ctrl
// PURPOSE
//  Sequences sample capture into the five channel RAMqueues as one circular buffer. Once run is set, writes one
//  address per decimated sample strobe, arms trigger logic when the pre-trigger region is full, then collects
//  trig_pos post-trigger samples. On completion it pulses set_capture_done to cmd_cfg and presents ram_addr
//  (oldest valid sample) so cmd_cfg can dump the channels in chronological order.
// PARAMETERS
//  ENTRIES  384  depth of each RAMqueue (samples)
//  LOG2     9    address width, ceil(log2(ENTRIES))
// PORTS
//  clk               in   1     system clock
//  rst_n             in   1     synchronous active-low reset
//  run               in   1     TrigCfg run bit; level, capture proceeds while high
//  capture_done      in   1     TrigCfg capture_done status bit; new capture blocked while high
//  wrt_smpl          in   1     1-cycle strobe per decimated sample
//  triggered         in   1     level from trigger logic
//  trig_pos          in   LOG2  post-trigger sample count
//  we                out  1     RAMqueue write enable, shared by all channels
//  waddr             out  LOG2  RAMqueue write address
//  armed             out  1     pre-trigger region full; trigger may be accepted
//  set_capture_done  out  1     1-cycle pulse at capture end
//  ram_addr          out  LOG2  oldest-sample address, valid after set_capture_done
// BEHAVIOUR
//  - States: IDLE, PRE (fill pre-trigger), WAIT_TRIG, POST, DONE. Reset: IDLE, we=0, waddr=0, armed=0,
//    set_capture_done=0, ram_addr=0, all counters 0. Reset honoured in every state; mid-capture reset aborts.
//  - Effective trig_pos: trig_pos >= ENTRIES clamps to ENTRIES-1. PRE_LEN = ENTRIES - effective trig_pos (>=1).
//  - IDLE: run=1 and capture_done=0 -> PRE; on entry waddr=0, smpl_cnt=0, post_cnt=0.
//  - we = wrt_smpl while in PRE/WAIT_TRIG/POST (combinational); RAM writes at the same clk edge.
//    On each write, waddr increments next edge; ENTRIES-1 wraps to 0. No strobe = no write, no pointer move.
//  - PRE: smpl_cnt counts writes, saturates at ENTRIES. When the write making smpl_cnt == PRE_LEN occurs,
//    armed goes 1 next cycle and state -> WAIT_TRIG.
//  - WAIT_TRIG: triggered=1 -> POST next cycle. A write in the same cycle as the accepted trigger counts as
//    pre-trigger. triggered in IDLE/PRE is ignored.
//  - POST: each write increments post_cnt; the write making post_cnt == trig_pos -> DONE.
//    Effective trig_pos==0: WAIT_TRIG goes directly to DONE on trigger, no post-trigger writes.
//  - DONE (one cycle): set_capture_done=1, armed=0, ram_addr <= current waddr (next write slot = oldest sample
//    once buffer full; waddr already wrapped). Next state IDLE. ram_addr held until next DONE or reset.
//  - IDLE re-entry requires capture_done low (host cleared), preventing overwrite of an undumped capture.
//  - run falls in PRE/WAIT_TRIG/POST: abort to IDLE next cycle, armed=0, no set_capture_done, ram_addr unchanged;
//    a wrt_smpl in the same cycle as run falling is not written.
//  - trig_pos sampled at IDLE->PRE exit; changes during capture ignored.
// TESTING
//  1. trig_pos=128, run=1, wrt_smpl every cycle, triggered held 1 -> armed rises after write to addr 255;
//     writes 0..383 then 0 (385 total); set_capture_done single pulse; ram_addr=1.
//  2. trig_pos=128, triggered pulsed at write 100 -> ignored; pulse again after armed -> 128 post writes, done.
//  3. Drop run at write 50 -> we stops within 1 cycle, armed=0, no set_capture_done, state IDLE.
//  4. trig_pos=0, trigger after armed at waddr=384-wrap point -> set_capture_done next cycle, ram_addr=0.
//  5. wrt_smpl every 4th cycle -> waddr advances exactly once per strobe; no we between strobes.
//  6. Assert rst_n=0 for 1 cycle during POST -> all outputs reset next edge; capture_done=1 + run=1 stays IDLE.

Source files
------------

// File: rtl/capture_ctrl.sv
// Capture sequencer: drives the channel RAMqueues as one circular buffer,
// fills pre-trigger, arms, collects post-trigger samples, reports oldest slot.
module capture_ctrl #(
    parameter int ENTRIES = 384,
    parameter int LOG2    = 9
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            run,
    input  logic            capture_done,
    input  logic            wrt_smpl,
    input  logic            triggered,
    input  logic [LOG2-1:0] trig_pos,
    output logic            we,
    output logic [LOG2-1:0] waddr,
    output logic            armed,
    output logic            set_capture_done,
    output logic [LOG2-1:0] ram_addr
);

    localparam int CW = LOG2 + 1;
    localparam logic [LOG2-1:0] LAST = LOG2'(ENTRIES - 1);
    localparam logic [CW-1:0]   ENT  = CW'(ENTRIES);

    typedef enum logic [2:0] {
        IDLE,
        PRE,
        WAIT_TRIG,
        POST,
        DONE
    } state_t;

    state_t state, state_n;

    logic [LOG2-1:0] tp_q;
    logic [LOG2-1:0] tp_eff;
    logic [CW-1:0]   pre_len;
    logic [CW-1:0]   smpl_cnt;
    logic [CW-1:0]   smpl_inc;
    logic [CW-1:0]   post_cnt;
    logic [CW-1:0]   post_inc;
    logic            active;

    assign tp_eff   = ({1'b0, trig_pos} >= ENT) ? LAST : trig_pos;
    assign pre_len  = ENT - {1'b0, tp_q};
    assign smpl_inc = (smpl_cnt == ENT) ? smpl_cnt : smpl_cnt + CW'(1);
    assign post_inc = post_cnt + CW'(1);

    always_comb begin
        state_n          = state;
        active           = 1'b0;
        we               = 1'b0;
        set_capture_done = 1'b0;
        unique case (state)
            IDLE: begin
                if (run && !capture_done)
                    state_n = PRE;
            end
            PRE: begin
                active = 1'b1;
                we     = run && wrt_smpl;
                if (!run)
                    state_n = IDLE;
                else if (we && smpl_inc == pre_len)
                    state_n = WAIT_TRIG;
            end
            WAIT_TRIG: begin
                active = 1'b1;
                we     = run && wrt_smpl;
                if (!run)
                    state_n = IDLE;
                else if (triggered)
                    state_n = (tp_q == '0) ? DONE : POST;
            end
            POST: begin
                active = 1'b1;
                we     = run && wrt_smpl;
                if (!run)
                    state_n = IDLE;
                else if (we && post_inc == {1'b0, tp_q})
                    state_n = DONE;
            end
            DONE: begin
                set_capture_done = 1'b1;
                state_n          = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    // armed stays high from pre-trigger full until the capture ends or aborts
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= IDLE;
            waddr    <= '0;
            armed    <= 1'b0;
            ram_addr <= '0;
            tp_q     <= '0;
            smpl_cnt <= '0;
            post_cnt <= '0;
        end else begin
            state <= state_n;
            armed <= (state_n == WAIT_TRIG) || (state_n == POST);
            if (state == IDLE && state_n == PRE) begin
                waddr    <= '0;
                smpl_cnt <= '0;
                post_cnt <= '0;
                tp_q     <= tp_eff;
            end
            if (we && active) begin
                waddr <= (waddr == LAST) ? '0 : waddr + LOG2'(1);
                if (state == POST)
                    post_cnt <= post_inc;
                else
                    smpl_cnt <= smpl_inc;
            end
            if (state == DONE)
                ram_addr <= waddr;
        end
    end

endmodule

// File: tb/tb_capture_ctrl.sv
// Scoreboard bench for capture_ctrl: stimulus queues expected write
// addresses and ram_addr values, a negedge monitor pops and compares.
module tb_capture_ctrl;

    localparam int ENTRIES = 384;
    localparam int LOG2    = 9;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            run = 1'b0;
    logic            capture_done = 1'b0;
    logic            wrt_smpl = 1'b0;
    logic            triggered = 1'b0;
    logic [LOG2-1:0] trig_pos = '0;
    logic            we;
    logic [LOG2-1:0] waddr;
    logic            armed;
    logic            set_capture_done;
    logic [LOG2-1:0] ram_addr;

    capture_ctrl #(.ENTRIES(ENTRIES), .LOG2(LOG2)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .run              (run),
        .capture_done     (capture_done),
        .wrt_smpl         (wrt_smpl),
        .triggered        (triggered),
        .trig_pos         (trig_pos),
        .we               (we),
        .waddr            (waddr),
        .armed            (armed),
        .set_capture_done (set_capture_done),
        .ram_addr         (ram_addr)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int fails = 0;
    int done_seen = 0;
    bit pend = 1'b0;
    logic [LOG2-1:0] wq[$];
    logic [LOG2-1:0] dq[$];

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (pend) begin
            pend = 1'b0;
            chk("done_pulse_width", set_capture_done, 0);
            checks++;
            if (dq.size() == 0) begin
                fails++;
                $display("FAIL unexpected_done: got ram_addr %0d expected none",
                         ram_addr);
            end else begin
                checks--;
                chk("ram_addr", ram_addr, dq.pop_front());
            end
        end else if (set_capture_done) begin
            pend = 1'b1;
        end
        if (we === 1'b1) begin
            checks++;
            if (wq.size() == 0) begin
                fails++;
                $display("FAIL unexpected_write: got waddr %0d expected no write",
                         waddr);
            end else begin
                checks--;
                chk("waddr", waddr, wq.pop_front());
            end
        end
    end

    task automatic step(input logic ws, input logic tr);
        wrt_smpl  = ws;
        triggered = tr;
        @(posedge clk);
        #1;
        if (set_capture_done === 1'b1) begin
            capture_done = 1'b1;
            done_seen++;
        end
    endtask

    task automatic start(input logic [LOG2-1:0] tp, input logic tr);
        trig_pos = tp;
        run      = 1'b1;
        step(1'b0, tr);
    endtask

    task automatic strobes(input int n, input int first, input int gap);
        for (int i = 0; i < n; i++) begin
            wq.push_back(LOG2'((first + i) % ENTRIES));
            step(1'b1, 1'b0);
            for (int g = 0; g < gap; g++) step(1'b0, 1'b0);
        end
    endtask

    task automatic wait_done(input string name, input int target);
        int n = 0;
        while (done_seen < target && n < 50) begin
            step(1'b0, 1'b0);
            n++;
        end
        chk(name, done_seen, target);
    endtask

    task automatic finish_capture();
        run = 1'b0;
        step(1'b0, 1'b0);
        capture_done = 1'b0;
        step(1'b0, 1'b0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (2) @(posedge clk);
        #1;
        chk("rst_we", we, 0);
        chk("rst_waddr", waddr, 0);
        chk("rst_armed", armed, 0);
        chk("rst_done", set_capture_done, 0);
        chk("rst_ram_addr", ram_addr, 0);
        rst_n = 1'b1;
        step(1'b0, 1'b0);

        // 1: trig_pos 128, trigger held, strobe every cycle
        dq.push_back(9'd1);
        start(9'd128, 1'b1);
        for (int i = 0; i < 385; i++) begin
            if (i == 255) chk("t1_armed_before", armed, 0);
            if (i == 256) chk("t1_armed_after", armed, 1);
            wq.push_back(LOG2'(i % ENTRIES));
            step(1'b1, 1'b1);
        end
        wait_done("t1_done", 1);
        step(1'b1, 1'b0);
        step(1'b1, 1'b0);
        chk("t1_armed_cleared", armed, 0);
        chk("t1_blocked_waddr", waddr, 1);
        finish_capture();

        // 3: abort at write 50
        start(9'd128, 1'b0);
        strobes(50, 0, 0);
        run = 1'b0;
        step(1'b1, 1'b0);
        chk("t3_we", we, 0);
        chk("t3_armed", armed, 0);
        step(1'b1, 1'b0);
        step(1'b1, 1'b0);
        chk("t3_waddr_frozen", waddr, 50);
        chk("t3_no_done", done_seen, 1);
        chk("t3_ram_addr_kept", ram_addr, 1);

        // 2+5: early trigger ignored, late pulse, sparse strobes
        dq.push_back(9'd0);
        start(9'd128, 1'b0);
        for (int i = 0; i < 256; i++) begin
            wq.push_back(LOG2'(i));
            step(1'b1, i == 100);
        end
        chk("t2_armed", armed, 1);
        repeat (3) step(1'b0, 1'b0);
        chk("t2_armed_wait", armed, 1);
        step(1'b0, 1'b1);
        strobes(128, 256, 3);
        wait_done("t2_done", 2);
        chk("t2_armed_cleared", armed, 0);
        finish_capture();

        // 4: trig_pos 0, trigger at wrap point
        dq.push_back(9'd0);
        start(9'd0, 1'b0);
        strobes(384, 0, 0);
        chk("t4_armed", armed, 1);
        chk("t4_wrap", waddr, 0);
        step(1'b0, 1'b1);
        chk("t4_done_next", set_capture_done, 1);
        chk("t4_done_cnt", done_seen, 3);
        finish_capture();

        // clamp: trig_pos 400 -> 383 post, 1 pre; write with trigger is pre
        dq.push_back(9'd1);
        start(9'd400, 1'b0);
        strobes(1, 0, 0);
        chk("t7_armed", armed, 1);
        wq.push_back(9'd1);
        step(1'b1, 1'b1);
        strobes(383, 2, 0);
        wait_done("t7_done", 4);
        finish_capture();

        // 6: reset during POST, then blocked by capture_done
        start(9'd128, 1'b0);
        strobes(256, 0, 0);
        step(1'b0, 1'b1);
        strobes(10, 256, 0);
        rst_n = 1'b0;
        step(1'b0, 1'b0);
        chk("t6_we", we, 0);
        chk("t6_waddr", waddr, 0);
        chk("t6_armed", armed, 0);
        chk("t6_done", set_capture_done, 0);
        chk("t6_ram_addr", ram_addr, 0);
        rst_n = 1'b1;
        capture_done = 1'b1;
        repeat (4) step(1'b1, 1'b0);
        chk("t6_stay_idle", waddr, 0);
        chk("t6_done_cnt", done_seen, 4);
        run = 1'b0;
        capture_done = 1'b0;
        repeat (3) step(1'b0, 1'b0);

        chk("wq_drained", wq.size(), 0);
        chk("dq_drained", dq.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures",
                 checks, fails);
        $finish;
    end

endmodule
